// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter states, timing defaults and
// keyboard command bytes.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_WAIT_CLK,
    ST_TX,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERROR
  } ps2_tx_state_e;

  localparam int PS2_TIMER_W        = 20;
  localparam int PS2_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
  localparam int PS2_START_TIMEOUT  = 750000;  // 15 ms at 50 MHz
  localparam int PS2_XFER_TIMEOUT   = 100000;  // 2 ms at 50 MHz
  localparam int PS2_REQUEST_CYCLES = 10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line with falling-edge detect.
// Flops reset to 1 because an idle, released line reads high.
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic line_p0, line_p1, line_p2;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      line_p0 <= line;
      line_p1 <= line_p0;
      line_p2 <= line_p1;
    end
  end

  assign level = line_p1;
  assign fall  = line_p2 & ~line_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift
// data/parity/stop on device clock falling edges, then check the acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  // Limits are compared against the last count so each phase lasts exactly N cycles.
  localparam logic [PS2_TIMER_W-1:0] INHIBIT_LAST = PS2_TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_TIMER_W-1:0] REQUEST_LAST = PS2_TIMER_W'(PS2_REQUEST_CYCLES - 1);
  localparam logic [PS2_TIMER_W-1:0] START_LAST   = PS2_TIMER_W'(START_TIMEOUT - 1);
  localparam logic [PS2_TIMER_W-1:0] XFER_LAST    = PS2_TIMER_W'(XFER_TIMEOUT - 1);

  ps2_tx_state_e           state, state_nxt;
  logic [PS2_TIMER_W-1:0]  timer, timer_nxt, timer_inc;
  logic [3:0]              bit_cnt, bit_cnt_nxt;
  logic                    dat_rel, dat_rel_nxt;
  logic                    err_timeout, err_timeout_nxt;
  logic                    load;
  logic [8:0]              tx_word;
  logic                    clk_level, clk_fall, dat_level, dat_fall_unused;
  logic                    clk_low, dat_low;

  ps2_line_sync u_clk_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line     (PS2_CLK),
    .level    (clk_level),
    .fall     (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line     (PS2_DAT),
    .level    (dat_level),
    .fall     (dat_fall_unused)
  );

  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      dat_rel     <= 1'b1;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      bit_cnt     <= bit_cnt_nxt;
      dat_rel     <= dat_rel_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

  // Captured command with its odd parity; bit 8 is the parity bit.
  always_ff @(posedge CLOCK_50) begin
    if (load) tx_word <= {odd_parity(the_command), the_command};
  end

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer_inc;
    bit_cnt_nxt     = bit_cnt;
    dat_rel_nxt     = dat_rel;
    err_timeout_nxt = err_timeout;
    load            = 1'b0;
    unique case (state)
      ST_IDLE: begin
        timer_nxt   = '0;
        bit_cnt_nxt = '0;
        dat_rel_nxt = 1'b1;
        if (send_command) begin
          load      = 1'b1;
          state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: if (timer >= INHIBIT_LAST) begin
        timer_nxt = '0;
        state_nxt = ST_REQUEST;
      end
      ST_REQUEST: if (timer >= REQUEST_LAST) begin
        timer_nxt = '0;
        state_nxt = ST_WAIT_CLK;
      end
      ST_WAIT_CLK: begin
        if (clk_fall) begin
          timer_nxt   = '0;
          dat_rel_nxt = tx_word[0];
          bit_cnt_nxt = 4'd1;
          state_nxt   = ST_TX;
        end else if (timer >= START_LAST) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = ST_ERROR;
        end
      end
      ST_TX: begin
        if (clk_fall) begin
          bit_cnt_nxt = bit_cnt + 4'd1;
          dat_rel_nxt = (bit_cnt <= 4'd8) ? tx_word[bit_cnt] : 1'b1;
          if (bit_cnt == 4'd9) state_nxt = ST_WAIT_ACK;
        end else if (timer >= XFER_LAST) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = ST_ERROR;
        end
      end
      ST_WAIT_ACK: begin
        if (clk_fall) begin
          err_timeout_nxt = 1'b0;
          state_nxt       = dat_level ? ST_ERROR : ST_WAIT_IDLE;
        end else if (timer >= XFER_LAST) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = ST_ERROR;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          state_nxt = ST_DONE;
        end else if (timer >= XFER_LAST) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = ST_ERROR;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERROR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign clk_low = (state == ST_INHIBIT) || (state == ST_REQUEST);
  assign dat_low = (state == ST_REQUEST) || (state == ST_WAIT_CLK) ||
                   ((state == ST_TX) && !dat_rel);

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign busy = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign command_was_sent              = (state == ST_DONE);
  assign error_communication_timed_out = (state == ST_ERROR) && err_timeout;
  assign error_no_ack                  = (state == ST_ERROR) && !err_timeout;

endmodule
